// File: rtl/mux_pipe_n_pkg.sv
// rtl/mux_pipe_n_pkg.sv - shared helpers for skid-based pipeline stages
package mux_pipe_n_pkg;

  // Occupancy of a 2-entry skid stage: main entry valid, then skid entry valid.
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

  // Select width for an n-way choice; never narrower than one bit.
  function automatic int sel_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mux_pipe_n_skid_buf.sv
// rtl/mux_pipe_n_skid_buf.sv - 2-entry valid/ready skid buffer with flush
module skid_buf
  import mux_pipe_n_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  input  logic             flush
);

  occ_e             state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             accept;
  logic             drain;

  // Ready depends only on registered occupancy, so out_ready never reaches upstream.
  assign in_ready  = (state_q != OCC_FULL);
  assign out_valid = (state_q != OCC_EMPTY);
  assign out_data  = main_q;
  assign accept    = in_valid && in_ready;
  assign drain     = out_valid && out_ready;

  // Occupancy register and the two data entries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= OCC_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  // Next occupancy and entry loads; flush drops everything but keeps out_data.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = OCC_EMPTY;
    end else begin
      case (state_q)
        OCC_EMPTY: begin
          if (accept) begin
            state_d = OCC_ONE;
            main_d  = in_data;
          end
        end
        OCC_ONE: begin
          if (accept && drain) begin
            main_d = in_data;
          end else if (accept) begin
            state_d = OCC_FULL;
            skid_d  = in_data;
          end else if (drain) begin
            state_d = OCC_EMPTY;
          end
        end
        OCC_FULL: begin
          if (drain) begin
            state_d = OCC_ONE;
            main_d  = skid_q;
          end
        end
        default: state_d = OCC_EMPTY;
      endcase
    end
  end

endmodule

// File: rtl/mux_pipe_n.sv
// rtl/mux_pipe_n.sv - N-input pipelined selector with valid/ready and skid buffer
module mux_pipe_n
  import mux_pipe_n_pkg::*;
#(
  parameter  int WIDTH = 32,
  parameter  int N     = 4,
  localparam int SELW  = sel_width(N)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [SELW-1:0]    sel,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_valid,
  input  logic               out_ready,
  input  logic               flush,
  output logic               sel_err
);

  logic             sel_legal;
  logic [WIDTH-1:0] sel_data;
  logic             sel_valid;
  logic             buf_ready;
  logic             sel_err_q, sel_err_d;

  // Out-of-range codes only exist when N is not a power of two.
  assign sel_legal = (int'(sel) < N);

  // N:1 word and valid select; an illegal code selects nothing.
  always_comb begin
    sel_data  = '0;
    sel_valid = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (sel_legal && (sel == SELW'(i))) begin
        sel_data  = in_data[i*WIDTH +: WIDTH];
        sel_valid = in_valid[i];
      end
    end
  end

  // One-hot ready towards the selected channel, forced low during reset.
  always_comb begin
    in_ready = '0;
    for (int i = 0; i < N; i++) begin
      in_ready[i] = (sel == SELW'(i)) && sel_legal && buf_ready && rst_n;
    end
  end

  assign sel_err_d = !sel_legal && (|in_valid);
  assign sel_err   = sel_err_q;

  // One pulse per cycle in which a valid channel met an illegal select.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_err_q <= 1'b0;
    end else begin
      sel_err_q <= sel_err_d;
    end
  end

  skid_buf #(
    .WIDTH(WIDTH)
  ) u_skid_buf (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (sel_data),
    .in_valid (sel_valid),
    .in_ready (buf_ready),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .flush    (flush)
  );

endmodule

// File: tb/tb_mux_pipe_n.sv
// tb/tb_mux_pipe_n.sv - scoreboard bench for mux_pipe_n
module tb_mux_pipe_n;

  localparam int W  = 32;
  localparam int N  = 4;
  localparam int W3 = 8;
  localparam int N3 = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]     sel;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_valid, in_ready;
  logic [W-1:0]   out_data;
  logic           out_valid, out_ready, flush, sel_err;

  logic [1:0]       sel3;
  logic [N3*W3-1:0] in_data3;
  logic [N3-1:0]    in_valid3, in_ready3;
  logic [W3-1:0]    out_data3;
  logic             out_valid3, out_ready3, flush3, sel_err3;

  mux_pipe_n #(.WIDTH(W), .N(N)) dut (
    .clk(clk), .rst_n(rst_n), .sel(sel), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .flush(flush), .sel_err(sel_err)
  );

  mux_pipe_n #(.WIDTH(W3), .N(N3)) dut3 (
    .clk(clk), .rst_n(rst_n), .sel(sel3), .in_data(in_data3), .in_valid(in_valid3),
    .in_ready(in_ready3), .out_data(out_data3), .out_valid(out_valid3),
    .out_ready(out_ready3), .flush(flush3), .sel_err(sel_err3)
  );

  int compared = 0;
  int mismatched = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // Reference model: the buffered words in acceptance order, capacity two.
  logic [31:0] exp_q[$];
  int          occ = 0;
  logic        check_en = 1'b0;
  bit          m_drn, m_acc;
  logic [3:0]  exp_rdy;

  always @(negedge rst_n) begin
    occ = 0;
    exp_q.delete();
  end

  // Model update at the accepting edge, from the inputs held across it.
  always @(posedge clk) begin
    if (rst_n) begin
      m_drn = (occ > 0) && out_ready;
      m_acc = (occ < 2) && in_valid[sel];
      occ = occ - int'(m_drn) + int'(m_acc);
      if (m_acc) exp_q.push_back(in_data[sel*W +: W]);
      if (flush) begin
        occ = 0;
        exp_q.delete();
      end
    end
  end

  // Monitor: compare handshake outputs and pop words as they are drained.
  always @(negedge clk) begin
    if (rst_n && check_en) begin
      exp_rdy = (occ < 2) ? (4'b0001 << sel) : 4'b0000;
      chk("in_ready", 32'(in_ready), 32'(exp_rdy));
      chk("out_valid", 32'(out_valid), 32'(occ > 0));
      chk("sel_err", 32'(sel_err), 32'd0);
      if (out_valid && exp_q.size() > 0) begin
        chk("out_data", out_data, exp_q[0]);
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    sel = 2'd0; in_data = '0; in_valid = '0; out_ready = 1'b0; flush = 1'b0;
    sel3 = 2'd0; in_data3 = '0; in_valid3 = '0; out_ready3 = 1'b0; flush3 = 1'b0;

    // Reset state with every channel valid.
    in_valid = 4'hF;
    in_valid3 = 3'b111;
    #23;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_in_ready3", 32'(in_ready3), 32'd0);
    chk("rst_sel_err3", 32'(sel_err3), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    in_valid = '0;
    in_valid3 = '0;
    check_en = 1'b1;

    // First word: one-cycle latency.
    sel = 2'd2;
    in_data[2*W +: W] = 32'hA5A5_0002;
    in_valid = 4'b0100;
    out_ready = 1'b1;
    step();
    in_valid = '0;
    chk("first_valid", 32'(out_valid), 32'd1);
    chk("first_data", out_data, 32'hA5A5_0002);

    // Streaming across all channels.
    for (int i = 0; i < 8; i++) begin
      sel = 2'(i % 4);
      in_data[(i % 4)*W +: W] = 32'h5000_0000 + 32'(i);
      in_valid = 4'b0001 << (i % 4);
      step();
    end
    in_valid = '0;
    step();
    step();

    // Backpressure on channel 1.
    out_ready = 1'b0;
    sel = 2'd1;
    in_valid = 4'b0010;
    for (int i = 0; i < 3; i++) begin
      in_data[W +: W] = 32'hB000_0000 + 32'(i);
      step();
    end
    chk("bp_ready1", 32'(in_ready[1]), 32'd0);
    chk("bp_hold", out_data, 32'hB000_0000);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) step();
    in_valid = '0;
    for (int i = 0; i < 3; i++) step();

    // Flush while full with an accept attempt.
    out_ready = 1'b0;
    sel = 2'd0;
    in_valid = 4'b0001;
    in_data[0 +: W] = 32'hC000_0000;
    step();
    in_data[0 +: W] = 32'hC000_0001;
    step();
    in_data[0 +: W] = 32'hC000_0009;
    flush = 1'b1;
    step();
    flush = 1'b0;
    in_valid = '0;
    chk("flush_valid", 32'(out_valid), 32'd0);
    chk("flush_hold", out_data, 32'hC000_0000);
    step();
    step();

    // Illegal select on the 3-channel instance.
    sel3 = 2'd3;
    in_valid3 = 3'b111;
    in_data3 = 24'h112233;
    out_ready3 = 1'b1;
    #2;
    chk("illegal_ready3", 32'(in_ready3), 32'd0);
    step();
    chk("illegal_err3", 32'(sel_err3), 32'd1);
    chk("illegal_nodata3", 32'(out_valid3), 32'd0);
    sel3 = 2'd1;
    in_valid3 = '0;
    step();
    chk("illegal_err3_clear", 32'(sel_err3), 32'd0);
    chk("illegal_nodata3b", 32'(out_valid3), 32'd0);
    in_data3[W3 +: W3] = 8'h3C;
    in_valid3 = 3'b010;
    #1;
    chk("legal_ready3", 32'(in_ready3), 32'h2);
    step();
    in_valid3 = '0;
    chk("legal_valid3", 32'(out_valid3), 32'd1);
    chk("legal_data3", 32'(out_data3), 32'h3C);

    // Randomised traffic, backpressure and occasional flush.
    for (int i = 0; i < 400; i++) begin
      sel = 2'($urandom_range(0, 3));
      in_valid = 4'($urandom);
      for (int c = 0; c < N; c++) in_data[c*W +: W] = $urandom;
      out_ready = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 19) == 0);
      step();
    end
    flush = 1'b0;
    in_valid = '0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) step();

    // Asynchronous reset while full.
    out_ready = 1'b0;
    sel = 2'd3;
    in_valid = 4'b1000;
    in_data[3*W +: W] = 32'hD000_0000;
    step();
    in_data[3*W +: W] = 32'hD000_0001;
    step();
    in_valid = '0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_data", out_data, 32'd0);
    chk("arst_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    sel = 2'd0;
    in_data[0 +: W] = 32'hE000_0001;
    in_valid = 4'b0001;
    out_ready = 1'b1;
    step();
    in_valid = '0;
    chk("post_rst_valid", 32'(out_valid), 32'd1);
    chk("post_rst_data", out_data, 32'hE000_0001);
    step();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
